// File: rtl/program_loader_pkg.sv
// Shared types and default sizes for the instruction-FIFO program loader.
package program_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ldr_state_t;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 4;

endpackage

// File: rtl/program_loader.sv
// Streams prog_len host bytes into the CPU instruction FIFO through a one-entry holding register.
// Optional CHECKSUM_EN macro adds a running XOR checksum output of the bytes written.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    input  logic                  fifo_full,
    output logic                  wr,
    output logic [DATA_WIDTH-1:0] opcode,
    output logic                  busy,
    output logic                  done,
`ifdef CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

    ldr_state_t            state_q, state_d;
    logic                  hold_valid_q, hold_valid_d;
    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    logic [ADDR_WIDTH:0]   len_clamped;
    logic [ADDR_WIDTH:0]   count_plus1;
    logic [ADDR_WIDTH:0]   accepted;
    logic                  accept;

    assign len_clamped = (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
    assign count_plus1 = count_q + ONE;
    assign accepted    = count_q + {{ADDR_WIDTH{1'b0}}, hold_valid_q};
    assign accept      = src_valid & src_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            len_q        <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            len_q        <= len_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (len_clamped == '0) ? DONE : LOAD;
            LOAD:    if (wr && (count_plus1 == len_q)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The holding slot may be drained and refilled in the same cycle for 1 byte/cycle.
    always_comb begin
        busy      = (state_q == LOAD);
        done      = (state_q == DONE);
        wr        = busy & hold_valid_q & ~fifo_full;
        opcode    = hold_data_q;
        src_ready = busy & (~hold_valid_q | wr) & (accepted < len_q);
        count     = count_q;
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        len_d        = len_q;
        count_d      = count_q;
        if ((state_q == IDLE) && start) begin
            len_d   = len_clamped;
            count_d = '0;
        end
        if (wr) begin
            count_d      = count_plus1;
            hold_valid_d = 1'b0;
        end
        if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = src_data;
        end
    end

`ifdef CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if ((state_q == IDLE) && start) begin
            csum_d = '0;
        end else if (wr) begin
            csum_d = csum_q ^ hold_data_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    // No checksum state exists in this build.
`endif

endmodule

// File: tb/tb_program_loader.sv
// Directed table-driven bench for program_loader, with hand-written multi-cycle sequences.
module tb_program_loader;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [4:0] prog_len;
    logic       src_valid;
    logic [7:0] src_data;
    logic       src_ready;
    logic       fifo_full;
    logic       wr;
    logic [7:0] opcode;
    logic       busy;
    logic       done;
    logic [4:0] count;
`ifdef CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int n_tests;
    int n_fail;

    program_loader #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .prog_len  (prog_len),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .fifo_full (fifo_full),
        .wr        (wr),
        .opcode    (opcode),
        .busy      (busy),
        .done      (done),
`ifdef CHECKSUM_EN
        .checksum  (checksum),
`endif
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic       start;
        logic [4:0] len;
        logic       valid;
        logic [7:0] data;
        logic       full;
        logic       e_ready;
        logic       e_wr;
        logic [7:0] e_op;
        logic       e_busy;
        logic       e_done;
        logic [4:0] e_count;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(logic st, logic [4:0] ln, logic v, logic [7:0] d, logic f,
                                logic r, logic w, logic [7:0] op, logic b, logic dn,
                                logic [4:0] c);
        vec_t t;
        t.start = st; t.len = ln; t.valid = v; t.data = d; t.full = f;
        t.e_ready = r; t.e_wr = w; t.e_op = op; t.e_busy = b; t.e_done = dn; t.e_count = c;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic r, input logic w, input logic [7:0] op,
                              input logic b, input logic dn, input logic [4:0] c);
        check({tag, ".src_ready"}, 32'(src_ready), 32'(r));
        check({tag, ".wr"},        32'(wr),        32'(w));
        check({tag, ".opcode"},    32'(opcode),    32'(op));
        check({tag, ".busy"},      32'(busy),      32'(b));
        check({tag, ".done"},      32'(done),      32'(dn));
        check({tag, ".count"},     32'(count),     32'(c));
    endtask

    task automatic run_load(input string tag, input logic [4:0] len, input int offer,
                            input int exp_n, input logic [7:0] base);
        int acc;
        int wrs;
        int dones;
        int max_acc;
        acc = 0; wrs = 0; dones = 0; max_acc = 0;
        @(negedge clk);
        start = 1'b1; prog_len = len; src_valid = 1'b0; fifo_full = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 60 && dones == 0; cyc++) begin
            src_valid = (acc < offer);
            src_data  = base + 8'(acc);
            #1;
            if (wr) begin
                check({tag, ".op"}, 32'(opcode), 32'(base + 8'(wrs)));
                wrs++;
            end
            if (done) begin
                dones++;
                check({tag, ".count_at_done"}, 32'(count), 32'(exp_n));
            end
            if (src_valid && src_ready) acc++;
            @(negedge clk);
        end
        src_valid = 1'b0;
        check({tag, ".accepted"}, 32'(acc), 32'(exp_n));
        check({tag, ".writes"},   32'(wrs), 32'(exp_n));
        check({tag, ".done_seen"}, 32'(dones), 32'd1);
        #1;
        check({tag, ".done_after"}, 32'(done), 32'd0);
        check({tag, ".count_hold"}, 32'(count), 32'(exp_n));
    endtask

    initial begin
        n_tests = 0; n_fail = 0;
        reset_n = 1'b0; start = 1'b0; prog_len = '0; src_valid = 1'b0;
        src_data = '0; fifo_full = 1'b0;

        vecs[0]  = mk(1, 5'd3, 0, 8'h00, 0,  0, 0, 8'h00, 0, 0, 5'd0);
        vecs[1]  = mk(0, 5'd3, 1, 8'h11, 0,  1, 0, 8'h00, 1, 0, 5'd0);
        vecs[2]  = mk(0, 5'd3, 1, 8'h22, 0,  1, 1, 8'h11, 1, 0, 5'd0);
        vecs[3]  = mk(0, 5'd3, 1, 8'h33, 0,  1, 1, 8'h22, 1, 0, 5'd1);
        vecs[4]  = mk(0, 5'd3, 1, 8'h44, 0,  0, 1, 8'h33, 1, 0, 5'd2);
        vecs[5]  = mk(0, 5'd3, 0, 8'h00, 0,  0, 0, 8'h33, 0, 1, 5'd3);
        vecs[6]  = mk(0, 5'd3, 0, 8'h00, 0,  0, 0, 8'h33, 0, 0, 5'd3);
        vecs[7]  = mk(1, 5'd0, 0, 8'h00, 0,  0, 0, 8'h33, 0, 0, 5'd3);
        vecs[8]  = mk(0, 5'd0, 0, 8'h00, 0,  0, 0, 8'h33, 0, 1, 5'd0);
        vecs[9]  = mk(0, 5'd0, 0, 8'h00, 0,  0, 0, 8'h33, 0, 0, 5'd0);
        vecs[10] = mk(1, 5'd2, 0, 8'h00, 0,  0, 0, 8'h33, 0, 0, 5'd0);
        vecs[11] = mk(0, 5'd2, 1, 8'hA5, 0,  1, 0, 8'h33, 1, 0, 5'd0);
        vecs[12] = mk(0, 5'd2, 1, 8'hB6, 1,  0, 0, 8'hA5, 1, 0, 5'd0);
        vecs[13] = mk(1, 5'd7, 1, 8'hB6, 1,  0, 0, 8'hA5, 1, 0, 5'd0);
        vecs[14] = mk(0, 5'd2, 1, 8'hB6, 1,  0, 0, 8'hA5, 1, 0, 5'd0);
        vecs[15] = mk(0, 5'd2, 1, 8'hB6, 1,  0, 0, 8'hA5, 1, 0, 5'd0);
        vecs[16] = mk(0, 5'd2, 1, 8'hB6, 0,  1, 1, 8'hA5, 1, 0, 5'd0);
        vecs[17] = mk(0, 5'd2, 0, 8'h00, 0,  0, 1, 8'hB6, 1, 0, 5'd1);
        vecs[18] = mk(0, 5'd2, 0, 8'h00, 0,  0, 0, 8'hB6, 0, 1, 5'd2);
        vecs[19] = mk(0, 5'd2, 0, 8'h00, 0,  0, 0, 8'hB6, 0, 0, 5'd2);

        #3;
        check_outs("reset", 0, 0, 8'h00, 0, 0, 5'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Cycle traces: 3-byte stream, zero-length load, fifo_full stall.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = vecs[i].start; prog_len = vecs[i].len; src_valid = vecs[i].valid;
            src_data = vecs[i].data; fifo_full = vecs[i].full;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_wr, vecs[i].e_op,
                       vecs[i].e_busy, vecs[i].e_done, vecs[i].e_count);
        end
        start = 1'b0; src_valid = 1'b0;

        run_load("full16", 5'd16, 18, 16, 8'h40);
        run_load("clamp20", 5'd20, 20, 16, 8'h80);

        // Reset in the middle of a 5-byte load after two writes.
        @(negedge clk);
        start = 1'b1; prog_len = 5'd5;
        @(negedge clk);
        start = 1'b0; src_valid = 1'b1; src_data = 8'h01;
        @(negedge clk);
        src_data = 8'h02;
        @(negedge clk);
        src_data = 8'h03;
        @(negedge clk);
        src_data = 8'h04;
        #1;
        check("midrst.count_before", 32'(count), 32'd2);
        check("midrst.wr_before", 32'(wr), 32'd1);
        reset_n = 1'b0;
        #1;
        check_outs("midrst", 0, 0, 8'h00, 0, 0, 5'd0);
        @(negedge clk);
        #1;
        check("midrst.wr_held", 32'(wr), 32'd0);
        src_valid = 1'b0;
        reset_n = 1'b1;
        run_load("after_rst", 5'd1, 3, 1, 8'hC0);

`ifdef CHECKSUM_EN
        begin
            logic [7:0] bytes[3];
            int k;
            int seen;
            bytes[0] = 8'h0F; bytes[1] = 8'hF0; bytes[2] = 8'h55;
            k = 0; seen = 0;
            @(negedge clk);
            start = 1'b1; prog_len = 5'd3;
            @(negedge clk);
            start = 1'b0;
            for (int cyc = 0; cyc < 30 && seen == 0; cyc++) begin
                src_valid = (k < 3);
                src_data  = (k < 3) ? bytes[k] : 8'h00;
                #1;
                if (done) seen = 1;
                if (src_valid && src_ready) k++;
                @(negedge clk);
            end
            src_valid = 1'b0;
            check("csum.done_seen", 32'(seen), 32'd1);
            #1;
            check("csum.value", 32'(checksum), 32'h0000_00AA);
            @(negedge clk);
            start = 1'b1; prog_len = 5'd1;
            @(negedge clk);
            start = 1'b0;
            #1;
            check("csum.cleared", 32'(checksum), 32'd0);
            @(negedge clk);
            src_valid = 1'b1; src_data = 8'h3C;
            @(negedge clk);
            src_valid = 1'b0;
            repeat (3) @(negedge clk);
            #1;
            check("csum.single", 32'(checksum), 32'h0000_003C);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
